// File: rtl/pc_unit_rv32i_if.sv
// Interface between the branch/trap logic (master) and the PC unit (slave).
// Redirect and trap controls flow in; the fetch address and status flow out.
interface pc_unit_rv32i_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             redirect_en;
  logic [XLEN-1:0]  redirect_target;
  logic             trap_en;
  logic [XLEN-1:0]  PC;
  logic [XLEN-1:0]  PC_4_inc;
  logic             pc_valid;
  logic             misalign_err;
  logic [XLEN-1:0]  err_addr;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    output stall, redirect_en, redirect_target, trap_en,
    input  PC, PC_4_inc, pc_valid, misalign_err, err_addr, fetch_cnt
  );

  modport slave (
    input  stall, redirect_en, redirect_target, trap_en,
    output PC, PC_4_inc, pc_valid, misalign_err, err_addr, fetch_cnt
  );
endinterface

// File: rtl/pc_unit_rv32i.sv
// RV32I fetch-stage program counter. Owns the PC register and selects the
// next PC from sequential increment, branch/jump redirect or trap vector.
// A misaligned redirect parks the unit in an error state that only a trap
// leaves. Also counts issued fetches.
module pc_unit_rv32i #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              CNT_W        = 16
) (
  input logic            clock,
  input logic            reset,
  pc_unit_rv32i_if.slave bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_ERR} state_t;

  // Low target bits that must be zero; an all-zero mask when ALIGN_BITS is 0.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t           r_state,    w_state_nxt;
  logic [XLEN-1:0]  r_pc,       w_pc_nxt;
  logic             r_valid,    w_valid_nxt;
  logic             r_err,      w_err_nxt;
  logic [XLEN-1:0]  r_err_addr, w_err_addr_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;

  logic [XLEN-1:0]  w_pc_inc;
  logic             w_misalign;

  assign w_pc_inc   = r_pc + XLEN'(INC);
  assign w_misalign = |(bus.redirect_target & ALIGN_MASK);

  // State register; reset forces boot values immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      r_err_addr <= w_err_addr_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Next-state and next-PC selection: trap > redirect > stall > increment.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_valid_nxt    = r_valid;
    w_err_nxt      = r_err;
    w_err_addr_nxt = r_err_addr;
    w_cnt_nxt      = r_cnt;
    unique case (r_state)
      // One-cycle bubble after reset: PC stays at the reset vector.
      S_BOOT: begin
        w_state_nxt = S_RUN;
        w_valid_nxt = 1'b1;
      end
      S_RUN: begin
        if (bus.trap_en) begin
          w_pc_nxt  = TRAP_VECTOR;
          w_cnt_nxt = r_cnt + 1'b1;
        end else if (bus.redirect_en) begin
          if (w_misalign) begin
            w_state_nxt    = S_ERR;
            w_err_nxt      = 1'b1;
            w_err_addr_nxt = bus.redirect_target;
            w_valid_nxt    = 1'b0;
          end else begin
            w_pc_nxt = bus.redirect_target;
            // A fetch is only counted when stall is low, even if redirecting.
            if (!bus.stall) w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (!bus.stall) begin
          w_pc_nxt  = w_pc_inc;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      // Frozen until a trap; stall and redirect are ignored here.
      S_ERR: begin
        if (bus.trap_en) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = TRAP_VECTOR;
          w_err_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  assign bus.PC           = r_pc;
  assign bus.PC_4_inc     = w_pc_inc;
  assign bus.pc_valid     = r_valid;
  assign bus.misalign_err = r_err;
  assign bus.err_addr     = r_err_addr;
  assign bus.fetch_cnt    = r_cnt;

endmodule

// File: tb/tb_pc_unit_rv32i.sv
// Table-driven bench for pc_unit_rv32i with an expected-result queue,
// plus hand-written asynchronous-reset sequences.
module tb_pc_unit_rv32i;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pc_unit_rv32i_if #(.XLEN(32), .CNT_W(16)) bus ();

  pc_unit_rv32i dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        st, rd, tr;
    logic [31:0] tgt;
    logic [31:0] pc, inc;
    logic        vld, err;
    logic [31:0] ea;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic st, rd, tr, input logic [31:0] tgt,
                              input logic [31:0] pc, input logic vld, err,
                              input logic [31:0] ea, input int cnt);
    vec_t v;
    v.st = st; v.rd = rd; v.tr = tr; v.tgt = tgt;
    v.pc = pc; v.inc = pc + 32'd4; v.vld = vld; v.err = err;
    v.ea = ea; v.cnt = 16'(cnt);
    return v;
  endfunction

  // Drive one cycle's inputs, queue the expectation, check after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clock);
    bus.stall = v.st; bus.redirect_en = v.rd; bus.trap_en = v.tr;
    bus.redirect_target = v.tgt;
    sbq.push_back(v);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    chk({tag, ".pc"},    bus.PC,                  e.pc);
    chk({tag, ".inc"},   bus.PC_4_inc,            e.inc);
    chk({tag, ".vld"},   32'(bus.pc_valid),       32'(e.vld));
    chk({tag, ".err"},   32'(bus.misalign_err),   32'(e.err));
    chk({tag, ".ea"},    bus.err_addr,            e.ea);
    chk({tag, ".cnt"},   32'(bus.fetch_cnt),      32'(e.cnt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pc"},  bus.PC,                32'h0);
    chk({tag, ".inc"}, bus.PC_4_inc,          32'h4);
    chk({tag, ".vld"}, 32'(bus.pc_valid),     32'h0);
    chk({tag, ".err"}, 32'(bus.misalign_err), 32'h0);
    chk({tag, ".ea"},  bus.err_addr,          32'h0);
    chk({tag, ".cnt"}, 32'(bus.fetch_cnt),    32'h0);
  endtask

  // Release reset just after an edge so the next edge is the first with reset low.
  task automatic release_reset(input string tag);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 chk_reset_vals(tag);
  endtask

  initial begin
    bus.stall = 1'b0; bus.redirect_en = 1'b0; bus.trap_en = 1'b0;
    bus.redirect_target = '0;

    // boot, wrap-around, stall, misalign/trap, simultaneous events
    tbl.push_back(mk(0,0,0,32'h0,        32'h0,        1,0,32'h0,0));
    tbl.push_back(mk(0,0,0,32'h0,        32'h4,        1,0,32'h0,1));
    tbl.push_back(mk(0,0,0,32'h0,        32'h8,        1,0,32'h0,2));
    tbl.push_back(mk(0,1,0,32'hFFFFFFF8, 32'hFFFFFFF8, 1,0,32'h0,3));
    tbl.push_back(mk(0,0,0,32'h0,        32'hFFFFFFFC, 1,0,32'h0,4));
    tbl.push_back(mk(0,0,0,32'h0,        32'h0,        1,0,32'h0,5));
    tbl.push_back(mk(0,1,0,32'h10,       32'h10,       1,0,32'h0,6));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,0,32'h0,      32'h10,       1,0,32'h0,6));
    tbl.push_back(mk(0,0,0,32'h0,        32'h14,       1,0,32'h0,7));
    tbl.push_back(mk(0,1,0,32'h12345679, 32'h14,       0,1,32'h12345679,7));
    tbl.push_back(mk(1,1,0,32'h200,      32'h14,       0,1,32'h12345679,7));
    tbl.push_back(mk(0,0,1,32'h0,        32'h100,      1,0,32'h12345679,8));
    tbl.push_back(mk(1,1,1,32'h201,      32'h100,      1,0,32'h12345679,9));
    tbl.push_back(mk(0,1,0,32'h28,       32'h28,       1,0,32'h12345679,10));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mk(0,0,0,32'h0, 32'h28 + 32'(4*k), 1,0,32'h12345679,10+k));

    #2 chk_reset_vals("rst0");
    release_reset("boot0");
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("v%0d", i));

    // Mid-cycle reset at PC=0x40, fetch_cnt=0x10: values change without an edge.
    #2 reset = 1'b1;
    #1 chk_reset_vals("arst1");
    release_reset("boot1");
    step(mk(0,0,0,32'h0, 32'h0, 1,0,32'h0,0), "rb0");
    step(mk(0,0,0,32'h0, 32'h4, 1,0,32'h0,1), "rb1");
    step(mk(0,1,0,32'h3, 32'h4, 0,1,32'h3,1), "rb2");

    // Reset while in the error state clears the sticky flag and address.
    #2 reset = 1'b1;
    #1 chk_reset_vals("arst2");
    release_reset("boot2");
    step(mk(0,0,0,32'h0, 32'h0, 1,0,32'h0,0), "rb3");

    if (sbq.size() != 0) begin
      total++;
      $display("FAIL sbq: %0d entries left want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
